// File: rtl/kat_adc_pkg.sv
// Shared definitions for the KATADC 3-wire programming engine.
//   FRAME_HEADER / FRAME_BITS : fixed 12-bit header and total frame length
//   DIV_W                     : width of the tick divider counter (CLK_DIV up to 255)
//   state_t                   : serial engine FSM states
//   build_frame()             : assembles {header, addr, data}
package kat_adc_pkg;

  localparam logic [11:0] FRAME_HEADER = 12'h001;
  localparam int          FRAME_BITS   = 32;
  localparam int          DIV_W        = $clog2(255 + 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SETUP  = 3'd1,
    BIT_LO = 3'd2,
    BIT_HI = 3'd3,
    HOLD   = 3'd4,
    GAP    = 3'd5,
    DONE   = 3'd6
  } state_t;

  function automatic logic [FRAME_BITS-1:0] build_frame(input logic [3:0]  addr,
                                                        input logic [15:0] data);
    return {FRAME_HEADER, addr, data};
  endfunction

endpackage

// File: rtl/kat_adc3wire_tick.sv
// Tick divider for the 3-wire engine.
//   clk     : system clock
//   rst     : synchronous active-high reset (counter to 0)
//   restart : synchronous restart, aligns the tick train to a new frame
//   tick    : high for one cycle every CLK_DIV cycles
// After a restart the first tick arrives CLK_DIV cycles later, so every
// FSM state that waits for a tick lasts exactly CLK_DIV cycles.
module kat_adc3wire_tick
  import kat_adc_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/kat_adc3wire_tx.sv
// Serial programming engine for one KATADC ADC.
//   OPB_Clk, OPB_Rst  : clock and synchronous active-high reset
//   config_addr/data  : register address/data, captured when a start is accepted
//   config_start      : level request, accepted only while idle
//   config_idle       : high only while idle
//   config_done       : one-cycle pulse when a frame has completed
//   adc3wire_clk      : serial clock (idle low)
//   adc3wire_data     : serial data, MSB first (idle low)
//   adc3wire_strobe   : active-low frame select (idle high)
//   dbg_state         : current FSM state for observation
// Handshake: config_start is sampled on each rising clock edge; when the
// engine is idle and start is high the frame is captured and the engine
// goes busy on the next cycle. Starts while busy are ignored (no queueing).
// config_done pulses for one cycle and idle returns on the following cycle.
// All serial outputs are registered from the next-state values so each
// output reflects the state it belongs to with no combinational path.
module kat_adc3wire_tx
  import kat_adc_pkg::*;
#(
  parameter int CLK_DIV = 4   // half-period of adc3wire_clk in OPB_Clk cycles, 1..255
) (
  input  logic        OPB_Clk,
  input  logic        OPB_Rst,
  input  logic [15:0] config_data,
  input  logic [3:0]  config_addr,
  input  logic        config_start,
  output logic        config_idle,
  output logic        config_done,
  output logic        adc3wire_clk,
  output logic        adc3wire_data,
  output logic        adc3wire_strobe,
  output logic [2:0]  dbg_state
);

  state_t                state, state_n;
  logic [FRAME_BITS-1:0] shreg, shreg_n;
  logic [4:0]            bit_cnt, bit_cnt_n;
  logic                  tick;
  logic                  restart;
  logic                  idle_n, done_n, clk_n, data_n, strobe_n;

  kat_adc3wire_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk     (OPB_Clk),
    .rst     (OPB_Rst),
    .restart (restart),
    .tick    (tick)
  );

  always_comb begin
    state_n   = state;
    shreg_n   = shreg;
    bit_cnt_n = bit_cnt;
    restart   = 1'b0;

    case (state)
      IDLE: begin
        if (config_start) begin
          state_n   = SETUP;
          shreg_n   = build_frame(config_addr, config_data);
          bit_cnt_n = 5'(FRAME_BITS - 1);
          restart   = 1'b1;
        end
      end
      SETUP:  if (tick) state_n = BIT_LO;
      BIT_LO: if (tick) state_n = BIT_HI;
      BIT_HI: begin
        // Shift as the clock falls so data only moves while clk is low.
        if (tick) begin
          shreg_n = {shreg[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt == 5'd0) begin
            state_n = HOLD;
          end else begin
            bit_cnt_n = bit_cnt - 1'b1;
            state_n   = BIT_LO;
          end
        end
      end
      HOLD:    if (tick) state_n = GAP;
      GAP:     if (tick) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    idle_n   = (state_n == IDLE);
    done_n   = (state_n == DONE);
    clk_n    = (state_n == BIT_HI);
    strobe_n = !(state_n inside {SETUP, BIT_LO, BIT_HI, HOLD});
    data_n   = (state_n inside {SETUP, BIT_LO, BIT_HI}) ? shreg_n[FRAME_BITS-1] : 1'b0;
  end

  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      state           <= IDLE;
      shreg           <= '0;
      bit_cnt         <= '0;
      config_idle     <= 1'b1;
      config_done     <= 1'b0;
      adc3wire_clk    <= 1'b0;
      adc3wire_data   <= 1'b0;
      adc3wire_strobe <= 1'b1;
    end else begin
      state           <= state_n;
      shreg           <= shreg_n;
      bit_cnt         <= bit_cnt_n;
      config_idle     <= idle_n;
      config_done     <= done_n;
      adc3wire_clk    <= clk_n;
      adc3wire_data   <= data_n;
      adc3wire_strobe <= strobe_n;
    end
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_kat_adc3wire_tx.sv
// Testbench for kat_adc3wire_tx: one instance with CLK_DIV = 4 and one
// with CLK_DIV = 1 share clock and reset. A monitor decodes frames from the
// 3-wire pins and checks them against an expected-frame queue per instance.
module tb_kat_adc3wire_tx;

  localparam int          D0  = 4;
  localparam int          D1  = 1;
  localparam logic [11:0] HDR = 12'h001;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic [1:0]  start = 2'b00;
  logic [3:0]  addr0 = '0, addr1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  wire  [1:0]  idle, done, sclk, sdat, sstb;
  wire  [2:0]  st0, st1;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q0[$];
  logic [31:0] exp_q1[$];

  kat_adc3wire_tx #(.CLK_DIV(D0)) u_dut0 (
    .OPB_Clk(clk), .OPB_Rst(rst),
    .config_data(data0), .config_addr(addr0), .config_start(start[0]),
    .config_idle(idle[0]), .config_done(done[0]),
    .adc3wire_clk(sclk[0]), .adc3wire_data(sdat[0]), .adc3wire_strobe(sstb[0]),
    .dbg_state(st0)
  );

  kat_adc3wire_tx #(.CLK_DIV(D1)) u_dut1 (
    .OPB_Clk(clk), .OPB_Rst(rst),
    .config_data(data1), .config_addr(addr1), .config_start(start[1]),
    .config_idle(idle[1]), .config_done(done[1]),
    .adc3wire_clk(sclk[1]), .adc3wire_data(sdat[1]), .adc3wire_strobe(sstb[1]),
    .dbg_state(st1)
  );

  // scoreboard / protocol monitor
  logic       rst_edge = 1'b1;
  always @(posedge clk) rst_edge <= rst;

  int          low_cnt[2];
  int          bit_cnt[2];
  logic [31:0] frame[2];
  logic        pclk[2], pdat[2], pstb[2], pdone[2];

  always @(negedge clk) begin
    logic [31:0] expv;
    int          dv;
    for (int i = 0; i < 2; i++) begin
      dv = (i == 0) ? D0 : D1;
      if (rst_edge) begin
        low_cnt[i] = 0;
        bit_cnt[i] = 0;
        frame[i]   = '0;
      end else begin
        if (sclk[i] === 1'b1) begin
          checks++;
          if (sdat[i] !== pdat[i] || sstb[i] !== pstb[i]) begin
            errors++;
            $display("FAIL proto_clk_high dut%0d: data %b->%b strobe %b->%b while clk=1",
                     i, pdat[i], sdat[i], pstb[i], sstb[i]);
          end
        end
        if (sstb[i] === 1'b0) begin
          low_cnt[i]++;
          if (sclk[i] === 1'b1 && pclk[i] === 1'b0) begin
            frame[i] = {frame[i][30:0], sdat[i]};
            bit_cnt[i]++;
          end
        end else if (pstb[i] === 1'b0) begin
          checks++;
          if (low_cnt[i] != 66 * dv) begin
            errors++;
            $display("FAIL strobe_low dut%0d: got %0d cycles expected %0d", i, low_cnt[i], 66 * dv);
          end
          checks++;
          if (bit_cnt[i] != 32) begin
            errors++;
            $display("FAIL bit_count dut%0d: got %0d expected 32", i, bit_cnt[i]);
          end
          checks++;
          if ((i == 0 && exp_q0.size() == 0) || (i == 1 && exp_q1.size() == 0)) begin
            errors++;
            $display("FAIL unexpected_frame dut%0d: got %h expected no frame", i, frame[i]);
          end else begin
            expv = (i == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
            if (frame[i] !== expv) begin
              errors++;
              $display("FAIL frame_value dut%0d: got %h expected %h", i, frame[i], expv);
            end
          end
          low_cnt[i] = 0;
          bit_cnt[i] = 0;
          frame[i]   = '0;
        end
        if (done[i] === 1'b1) begin
          checks++;
          if (pdone[i] === 1'b1) begin
            errors++;
            $display("FAIL done_width dut%0d: got done high 2+ cycles expected 1", i);
          end
        end
      end
      pclk[i]  = sclk[i];
      pdat[i]  = sdat[i];
      pstb[i]  = sstb[i];
      pdone[i] = done[i];
    end
  end

  // driver tasks
  task automatic launch(input int u, input logic [3:0] a, input logic [15:0] d);
    if (u == 0) begin
      addr0 = a; data0 = d; exp_q0.push_back({HDR, a, d});
    end else begin
      addr1 = a; data1 = d; exp_q1.push_back({HDR, a, d});
    end
    start[u] = 1'b1;
  endtask

  task automatic measure(input int u, input bit hold, input int limit,
                         output int done_at, output int idle_at, output int done_cnt);
    done_at = -1; idle_at = -1; done_cnt = 0;
    for (int n = 1; n <= limit && idle_at < 0; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) start[u] = 1'b0;
      if (done[u] === 1'b1) begin
        done_cnt++;
        if (done_at < 0) done_at = n;
      end
      if (idle[u] === 1'b1) idle_at = n;
    end
  endtask

  // tests
  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++; if (idle[i] !== 1'b1) begin errors++; $display("FAIL reset_idle dut%0d: got %b expected 1", i, idle[i]); end
      checks++; if (done[i] !== 1'b0) begin errors++; $display("FAIL reset_done dut%0d: got %b expected 0", i, done[i]); end
      checks++; if (sstb[i] !== 1'b1) begin errors++; $display("FAIL reset_strobe dut%0d: got %b expected 1", i, sstb[i]); end
      checks++; if (sclk[i] !== 1'b0) begin errors++; $display("FAIL reset_clk dut%0d: got %b expected 0", i, sclk[i]); end
      checks++; if (sdat[i] !== 1'b0) begin errors++; $display("FAIL reset_data dut%0d: got %b expected 0", i, sdat[i]); end
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_single();
    int da, ia, dc;
    launch(0, 4'h1, 16'h7FFF);
    measure(0, 1'b0, 400, da, ia, dc);
    checks++; if (da != 67 * D0 + 1) begin errors++; $display("FAIL single_done_cycle: got %0d expected %0d", da, 67 * D0 + 1); end
    checks++; if (ia != 67 * D0 + 2) begin errors++; $display("FAIL single_idle_cycle: got %0d expected %0d", ia, 67 * D0 + 2); end
    checks++; if (dc != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", dc); end
    checks++; if (exp_q0.size() != 0) begin errors++; $display("FAIL single_frame_missing: got %0d pending expected 0", exp_q0.size()); end
  endtask

  task automatic test_random();
    int da, ia, dc, u, dv;
    for (int r = 0; r < 6; r++) begin
      u  = r % 2;
      dv = (u == 0) ? D0 : D1;
      launch(u, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
      measure(u, 1'b0, 67 * dv + 20, da, ia, dc);
      checks++; if (da != 67 * dv + 1) begin errors++; $display("FAIL rand_done_cycle dut%0d: got %0d expected %0d", u, da, 67 * dv + 1); end
      checks++; if (ia != 67 * dv + 2) begin errors++; $display("FAIL rand_idle_cycle dut%0d: got %0d expected %0d", u, ia, 67 * dv + 2); end
      checks++; if (dc != 1) begin errors++; $display("FAIL rand_done_count dut%0d: got %0d expected 1", u, dc); end
      checks++;
      if ((u == 0 ? exp_q0.size() : exp_q1.size()) != 0) begin
        errors++; $display("FAIL rand_frame_missing dut%0d: got pending frame expected none", u);
      end
    end
  endtask

  task automatic test_busy_start();
    int dc, da, early_idle, late_busy;
    dc = 0; da = -1; early_idle = 0; late_busy = 0;
    repeat (10) @(negedge clk);
    launch(0, 4'h2, 16'($urandom_range(0, 65535)));
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (n == 1) start[0] = 1'b0;
      if (n == 90) begin
        addr0 = 4'hC; data0 = 16'($urandom_range(0, 65535)); start[0] = 1'b1;
      end
      if (n == 91) start[0] = 1'b0;
      if (done[0] === 1'b1) begin dc++; if (da < 0) da = n; end
      if (n <= 67 * D0 + 1 && idle[0] === 1'b1) early_idle++;
      if (n >= 67 * D0 + 2 && idle[0] !== 1'b1) late_busy++;
    end
    checks++; if (dc != 1) begin errors++; $display("FAIL busy_done_count: got %0d expected 1", dc); end
    checks++; if (da != 67 * D0 + 1) begin errors++; $display("FAIL busy_done_cycle: got %0d expected %0d", da, 67 * D0 + 1); end
    checks++; if (early_idle != 0) begin errors++; $display("FAIL busy_idle_early: got %0d idle cycles expected 0", early_idle); end
    checks++; if (late_busy != 0) begin errors++; $display("FAIL busy_second_frame: got %0d busy cycles expected 0", late_busy); end
  endtask

  task automatic test_mid_reset();
    int dc, busy, da, ia, dc2;
    dc = 0; busy = 0;
    launch(0, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
    for (int n = 1; n <= 120; n++) begin
      @(negedge clk);
      if (n == 1) start[0] = 1'b0;
      if (n == 120) rst = 1'b1;
    end
    @(negedge clk);
    rst = 1'b0;
    exp_q0.delete();
    checks++; if (sstb[0] !== 1'b1) begin errors++; $display("FAIL midrst_strobe: got %b expected 1", sstb[0]); end
    checks++; if (sclk[0] !== 1'b0) begin errors++; $display("FAIL midrst_clk: got %b expected 0", sclk[0]); end
    checks++; if (sdat[0] !== 1'b0) begin errors++; $display("FAIL midrst_data: got %b expected 0", sdat[0]); end
    checks++; if (idle[0] !== 1'b1) begin errors++; $display("FAIL midrst_idle: got %b expected 1", idle[0]); end
    checks++; if (done[0] !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done[0]); end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (done[0] === 1'b1) dc++;
      if (idle[0] !== 1'b1) busy++;
    end
    checks++; if (dc != 0) begin errors++; $display("FAIL midrst_done_pulse: got %0d expected 0", dc); end
    checks++; if (busy != 0) begin errors++; $display("FAIL midrst_resumed: got %0d busy cycles expected 0", busy); end
    launch(0, 4'($urandom_range(0, 15)), 16'($urandom_range(0, 65535)));
    measure(0, 1'b0, 400, da, ia, dc2);
    checks++; if (da != 67 * D0 + 1) begin errors++; $display("FAIL midrst_new_done: got %0d expected %0d", da, 67 * D0 + 1); end
    checks++; if (exp_q0.size() != 0) begin errors++; $display("FAIL midrst_new_frame: got %0d pending expected 0", exp_q0.size()); end
  endtask

  task automatic test_back_to_back();
    int dn, idle_cnt, late_busy, p;
    int dt[3];
    dn = 0; idle_cnt = 0; late_busy = 0;
    p = 67 * D1 + 2;
    launch(1, 4'hF, 16'hA5A5);
    exp_q1.push_back({HDR, 4'hF, 16'hA5A5});
    exp_q1.push_back({HDR, 4'hF, 16'hA5A5});
    for (int n = 1; n <= 260; n++) begin
      @(negedge clk);
      if (n == 150) start[1] = 1'b0;
      if (done[1] === 1'b1) begin
        if (dn < 3) dt[dn] = n;
        dn++;
      end
      if (n <= 2 * p + 67 * D1 + 1 && idle[1] === 1'b1) idle_cnt++;
      if (n >= 3 * p && idle[1] !== 1'b1) late_busy++;
    end
    checks++; if (dn != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", dn); end
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (dn > k && dt[k] != 67 * D1 + 1 + k * p) begin
        errors++; $display("FAIL b2b_done_cycle%0d: got %0d expected %0d", k, dt[k], 67 * D1 + 1 + k * p);
      end
    end
    checks++; if (idle_cnt != 2) begin errors++; $display("FAIL b2b_idle_gap: got %0d idle cycles expected 2", idle_cnt); end
    checks++; if (late_busy != 0) begin errors++; $display("FAIL b2b_extra_frame: got %0d busy cycles expected 0", late_busy); end
    checks++; if (exp_q1.size() != 0) begin errors++; $display("FAIL b2b_frames_missing: got %0d pending expected 0", exp_q1.size()); end
  endtask

  task automatic test_collision();
    int busy, dc;
    busy = 0; dc = 0;
    rst = 1'b1;
    start[0] = 1'b1;
    addr0 = 4'($urandom_range(0, 15));
    @(negedge clk);
    rst = 1'b0;
    start[0] = 1'b0;
    checks++; if (idle[0] !== 1'b1) begin errors++; $display("FAIL collide_idle: got %b expected 1", idle[0]); end
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      if (idle[0] !== 1'b1) busy++;
      if (done[0] === 1'b1) dc++;
    end
    checks++; if (busy != 0) begin errors++; $display("FAIL collide_frame: got %0d busy cycles expected 0", busy); end
    checks++; if (dc != 0) begin errors++; $display("FAIL collide_done: got %0d expected 0", dc); end
  endtask

  initial begin
    #500000;
    errors++;
    $display("FAIL timeout: got no completion expected finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "timeout");
  end

  // final report
  initial begin
    test_reset();
    test_single();
    test_random();
    test_busy_start();
    test_mid_reset();
    test_back_to_back();
    test_collision();
    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
